sram_responder: RTL and testbench

- Synthesizable/behavioural model of the external 16-bit SRAM device. It is the device end of the SRAM bus driven by the system's SRAM controller: SRAM_ADDR, SRAM_WE_N and SRAM_DQ.
- Stores words, returns read data after a programmable access latency, and captures writes on the clock edge.
- Provides an optional post-reset clear sweep and access counters for the testbench.
- Sits in the top-level simulation and FPGA-emulation wrapper, connected directly to the controller pins.

---
 rtl/sram_responder.sv | 74 +++++++
 tb/tb_sram_responder.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_responder.sv
// sram_responder: device end of the 16-bit SRAM bus with programmable read latency,
// optional post-reset clear sweep and saturating access counters.
module sram_responder #(
    parameter int ADDR_W         = 18,
    parameter int DATA_W         = 16,
    parameter int RD_LAT         = 0,
    parameter bit CLEAR_ON_RESET = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] SRAM_ADDR,
    input  logic              SRAM_WE_N,
    inout  wire  [DATA_W-1:0] SRAM_DQ,
    output logic              busy,
    output logic [15:0]       rd_count,
    output logic [15:0]       wr_count
);
    localparam int SW = (RD_LAT < 1) ? 1 : $clog2(RD_LAT + 1);
    localparam logic [SW-1:0] LAT = SW'(RD_LAT);
    localparam logic [ADDR_W-1:0] LAST = '1;
    typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_READ, S_WRITE} state_t;
    state_t state_q, state_d;
    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [ADDR_W-1:0] addr_q, addr_d, clr_addr_q, clr_addr_d, mem_addr;
    logic [SW-1:0] stab_q, stab_d;
    logic [DATA_W-1:0] mem_wdata;
    logic [15:0] rd_count_d, wr_count_d;
    logic drove_q, drive, new_addr, rd_inc, mem_we;
    always_ff @(posedge clk)
        if (rst)
            state_q <= CLEAR_ON_RESET ? S_CLEAR : S_IDLE;
        else
            state_q <= state_d;
    always_comb
        state_d = (state_q == S_CLEAR) ? ((clr_addr_q == LAST) ? S_IDLE : S_CLEAR)
                                       : (SRAM_WE_N ? S_READ : S_WRITE);
    always_comb begin
        busy  = state_q == S_CLEAR;
        drive = !rst && !busy && SRAM_WE_N && (RD_LAT == 0 || stab_q == LAT);
    end
    // a read access is new when the address moved or the bus just came out of a write
    always_comb begin
        new_addr   = SRAM_ADDR != addr_q || state_q == S_WRITE;
        rd_inc     = drive && ((RD_LAT == 0) ? (SRAM_ADDR != addr_q || state_q != S_READ) : !drove_q);
        addr_d     = busy ? addr_q : SRAM_ADDR;
        stab_d     = (busy || !SRAM_WE_N || new_addr) ? '0 : ((stab_q == LAT) ? stab_q : stab_q + SW'(1));
        clr_addr_d = busy ? clr_addr_q + ADDR_W'(1) : clr_addr_q;
        mem_we     = busy || !SRAM_WE_N;
        mem_addr   = busy ? clr_addr_q : SRAM_ADDR;
        mem_wdata  = busy ? '0 : SRAM_DQ;
        rd_count_d = rd_count + 16'(rd_inc && rd_count != 16'hFFFF);
        wr_count_d = wr_count + 16'(!busy && !SRAM_WE_N && wr_count != 16'hFFFF);
    end
    always_ff @(posedge clk)
        if (rst) begin
            addr_q     <= '0;
            stab_q     <= '0;
            clr_addr_q <= '0;
            drove_q    <= 1'b0;
            rd_count   <= '0;
            wr_count   <= '0;
        end else begin
            addr_q     <= addr_d;
            stab_q     <= stab_d;
            clr_addr_q <= clr_addr_d;
            drove_q    <= drive;
            rd_count   <= rd_count_d;
            wr_count   <= wr_count_d;
        end
    always_ff @(posedge clk)
        if (!rst && mem_we)
            mem[mem_addr] <= mem_wdata;
    assign SRAM_DQ = drive ? mem[(RD_LAT == 0) ? SRAM_ADDR : addr_q] : 'z;
endmodule

// File: tb/tb_sram_responder.sv
// tb_sram_responder: two responders (async 18-bit, and 4-bit/latency-2/clearing) against a cycle reference model.
module tb_sram_responder;
    logic clk = 0;
    always #5 clk = ~clk;
    logic rst [2];
    logic we_n [2];
    logic [17:0] addr [2];
    logic [15:0] wdata [2];
    logic tb_oe [2];
    logic [15:0] tb_dq [2];
    wire [15:0] dq0, dq1;
    logic busy0, busy1;
    logic [15:0] rdc0, rdc1, wrc0, wrc1;
    assign dq0 = tb_oe[0] ? tb_dq[0] : 16'hzzzz;
    assign dq1 = tb_oe[1] ? tb_dq[1] : 16'hzzzz;

    sram_responder #(.ADDR_W(18), .DATA_W(16), .RD_LAT(0), .CLEAR_ON_RESET(0)) u_dut0 (
        .clk(clk), .rst(rst[0]), .SRAM_ADDR(addr[0]), .SRAM_WE_N(we_n[0]), .SRAM_DQ(dq0),
        .busy(busy0), .rd_count(rdc0), .wr_count(wrc0));
    sram_responder #(.ADDR_W(4), .DATA_W(16), .RD_LAT(2), .CLEAR_ON_RESET(1)) u_dut1 (
        .clk(clk), .rst(rst[1]), .SRAM_ADDR(addr[1][3:0]), .SRAM_WE_N(we_n[1]), .SRAM_DQ(dq1),
        .busy(busy1), .rd_count(rdc1), .wr_count(wrc1));

    int n_chk = 0;
    int n_pass = 0;
    bit chk_en = 1;
    logic [15:0] obs [2];
    logic [15:0] w [4];
    int busy_seen = 0;
    logic [15:0] rmem [int];
    int m_busy [2] = '{0, 0};
    int m_streak [2] = '{1, 1};
    logic [17:0] m_lat [2] = '{0, 0};
    bit m_pd [2] = '{0, 0};
    logic [17:0] m_pda [2] = '{0, 0};
    int m_rd [2] = '{0, 0};
    int m_wr [2] = '{0, 0};
    logic [17:0] pool [8] = '{18'h00000, 18'h3FFFF, 18'h3FFFE, 18'h00001,
                              18'h12345, 18'h20000, 18'h0FFFF, 18'h00080};

    function automatic int lat(input int k); return k ? 2 : 0; endfunction
    function automatic int words(input int k); return k ? 16 : (1 << 18); endfunction
    function automatic int key(input int k, input logic [17:0] a); return k * (1 << 20) + int'(a); endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        else
            n_pass++;
    endtask

    // one bus cycle on both devices: drive, sample at negedge, advance model at posedge, check counters
    task automatic step();
        bit drv [2];
        logic [17:0] da [2];
        for (int k = 0; k < 2; k++) begin
            drv[k] = !rst[k] && m_busy[k] == 0 && we_n[k] && (lat(k) == 0 || m_streak[k] > lat(k));
            da[k] = lat(k) == 0 ? addr[k] : m_lat[k];
            tb_oe[k] = !drv[k];
            tb_dq[k] = we_n[k] ? 16'h0000 : wdata[k];
        end
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            obs[k] = k ? dq1 : dq0;
            if (chk_en && (!drv[k] || rmem.exists(key(k, da[k]))))
                check($sformatf("dq%0d", k), obs[k], drv[k] ? rmem[key(k, da[k])] : tb_dq[k]);
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (rst[k]) begin
                m_busy[k] = k ? words(k) : 0;
                m_streak[k] = 1;
                m_lat[k] = 0;
                m_pd[k] = 0;
                m_rd[k] = 0;
                m_wr[k] = 0;
            end else begin
                if (drv[k] && !(m_pd[k] && m_pda[k] == da[k]) && m_rd[k] < 65535)
                    m_rd[k]++;
                m_pd[k] = drv[k];
                m_pda[k] = da[k];
                if (m_busy[k] > 0) begin
                    rmem[key(k, 18'(words(k) - m_busy[k]))] = 16'h0000;
                    m_busy[k]--;
                    m_streak[k] = 1;
                    m_lat[k] = 0;
                end else if (!we_n[k]) begin
                    rmem[key(k, addr[k])] = wdata[k];
                    if (m_wr[k] < 65535)
                        m_wr[k]++;
                    m_streak[k] = 0;
                    m_lat[k] = addr[k];
                end else begin
                    m_streak[k] = (m_streak[k] > 0 && addr[k] == m_lat[k]) ? m_streak[k] + 1 : 1;
                    m_lat[k] = addr[k];
                end
            end
        end
        #1;
        busy_seen = rst[1] ? int'(busy1) : busy_seen + int'(busy1);
        if (chk_en) begin
            check("rd0", rdc0, m_rd[0]);
            check("wr0", wrc0, m_wr[0]);
            check("busy0", busy0, m_busy[0] > 0);
            check("rd1", rdc1, m_rd[1]);
            check("wr1", wrc1, m_wr[1]);
            check("busy1", busy1, m_busy[1] > 0);
        end
    endtask

    task automatic wait_clear();
        for (int i = 0; i < 40 && busy1; i++)
            step();
        check("clr_done", busy1, 0);
        check("busy_cycles", busy_seen, 16);
    endtask

    task automatic rand_stim(input int k);
        we_n[k] = $urandom_range(0, 3) != 0;
        if (!we_n[k] || $urandom_range(0, 1) == 0)
            addr[k] = k ? 18'($urandom_range(0, 15)) : pool[$urandom_range(0, 7)];
        wdata[k] = 16'($urandom);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            rst[k] = 1;
            we_n[k] = 1;
            wdata[k] = 0;
            tb_oe[k] = 1;
            tb_dq[k] = 0;
        end
        addr[0] = 18'h00010;
        addr[1] = 0;
        step();
        step();
        check("rst_rd0", rdc0, 0);
        check("rst_busy1", busy1, 1);
        rst[0] = 0;
        rst[1] = 0;
        we_n[0] = 0;
        wdata[0] = 16'hBEEF;
        step();
        we_n[0] = 1;
        step();
        check("beef_dq", obs[0], 16'hBEEF);
        check("beef_wr", wrc0, 1);
        check("beef_rd", rdc0, 1);
        wait_clear();
        // fill, reset mid-sweep, then prove the sweep zeroes everything
        for (int i = 0; i < 16; i++) begin
            we_n[1] = 0;
            addr[1] = 18'(i);
            wdata[1] = 16'($urandom_range(1, 16'hFFFF));
            step();
        end
        we_n[1] = 1;
        rst[1] = 1;
        step();
        rst[1] = 0;
        for (int i = 0; i < 5; i++)
            step();
        rst[1] = 1;
        step();
        rst[1] = 0;
        wait_clear();
        for (int i = 0; i < 16; i++) begin
            addr[1] = 18'(i);
            for (int j = 0; j < 4; j++)
                step();
            check($sformatf("clr_mem%0d", i), obs[1], 16'h0000);
        end
        we_n[0] = 0;
        addr[0] = 18'h00080;
        wdata[0] = 16'h1234;
        step();
        addr[0] = 18'h00081;
        wdata[0] = 16'hCAFE;
        step();
        we_n[0] = 1;
        for (int i = 0; i < 4; i++) begin
            addr[0] = 18'h00080 + 18'(i);
            step();
            w[i] = obs[0];
        end
        check("mem80", w[0], 16'h1234);
        check("mem81", w[1], 16'hCAFE);
        check("rd32", {w[1], w[0]}, 32'hCAFE1234);
        we_n[1] = 0;
        addr[1] = 5;
        wdata[1] = 16'hA5A5;
        step();
        addr[1] = 6;
        wdata[1] = 16'h6666;
        step();
        we_n[1] = 1;
        addr[1] = 4;
        for (int i = 0; i < 4; i++)
            step();
        addr[1] = 5;
        step();
        step();
        check("lat_z1", obs[1], 16'h0000);
        step();
        check("lat_z2", obs[1], 16'h0000);
        step();
        check("lat_a5", obs[1], 16'hA5A5);
        addr[1] = 6;
        step();
        step();
        check("lat6_z1", obs[1], 16'h0000);
        step();
        check("lat6_z2", obs[1], 16'h0000);
        step();
        check("lat_66", obs[1], 16'h6666);
        we_n[0] = 0;
        wdata[0] = 16'h5555;
        for (int i = 0; i < 4; i++) begin
            addr[0] = 18'h00100 + 18'(i);
            step();
            check("turn", obs[0], 16'h5555);
        end
        we_n[0] = 1;
        for (int i = 0; i < 8; i++) begin
            we_n[0] = 0;
            addr[0] = pool[i];
            wdata[0] = 16'($urandom);
            step();
        end
        for (int i = 0; i < 400; i++) begin
            rand_stim(0);
            rand_stim(1);
            step();
        end
        we_n[0] = 1;
        we_n[1] = 1;
        addr[1] = 7;
        for (int i = 0; i < 4; i++)
            step();
        rst[1] = 1;
        step();
        check("rst_z", obs[1], 16'h0000);
        check("rst_rd1", rdc1, 0);
        check("rst_wr1", wrc1, 0);
        rst[1] = 0;
        step();
        check("post_rst_z", obs[1], 16'h0000);
        wait_clear();
        we_n[0] = 0;
        addr[0] = 18'h00020;
        wdata[0] = 16'h1111;
        chk_en = 0;
        for (int i = 0; i < 70000; i++)
            step();
        chk_en = 1;
        step();
        check("wr_sat", wrc0, 16'hFFFF);
        step();
        check("wr_hold", wrc0, 16'hFFFF);
        we_n[0] = 1;
        rst[0] = 1;
        step();
        check("rst_z0", obs[0], 16'h0000);
        check("rst_wr0", wrc0, 0);
        rst[0] = 0;
        step();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
